// File: rtl/cam_fifo_sequencer.sv
// Camera capture sequencer: tags camera bytes with sof/eol on their way into the pixel FIFO and
// drains the FIFO through a 2-entry buffer to a valid/ready consumer.
module cam_fifo_sequencer #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned BYTES_PER_LINE  = 640,
    parameter int unsigned LINES_PER_FRAME = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              cont,
    input  logic              clear_err,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_de,
    input  logic [DATA_W-1:0] cam_data,
    output logic              fifo_wr,
    output logic [DATA_W+1:0] fifo_wdata,
    input  logic              fifo_full,
    output logic              fifo_rd,
    input  logic [DATA_W+1:0] fifo_rdata,
    input  logic              fifo_empty,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              busy,
    output logic              frame_done,
    output logic              ovf,
    output logic              len_err
);
    localparam int unsigned BW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam int unsigned LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

    typedef enum logic [1:0] {StIdle, StWaitFrame, StActive, StFlush} state_e;

    state_e state_q, state_d;

    logic              vsync_q, href_q;
    logic [BW-1:0]     byte_cnt_q;
    logic [LW-1:0]     line_cnt_q;
    logic              line_full_q;
    logic              wr_q;
    logic [DATA_W+1:0] wdata_q;
    logic              ovf_q, len_err_q;
    logic              rd_inflight_q;
    logic [1:0]        buf_cnt_q;
    logic              buf_wptr_q, buf_rptr_q;
    logic [DATA_W+1:0] buf_mem_q [2];

    logic vsync_fall, vsync_rise, href_fall, in_active, accept, do_write;
    logic drop_full, drop_long, line_end, last_line, abort, drained, frame_start;
    logic tag_sof, tag_eol, pop;
    logic [1:0] rd_credit;

    assign vsync_fall  = vsync_q & ~cam_vsync;
    assign vsync_rise  = ~vsync_q & cam_vsync;
    assign href_fall   = href_q & ~cam_href;
    assign in_active   = (state_q == StActive);
    assign frame_start = (state_q == StWaitFrame) && vsync_fall;
    assign accept      = in_active && cam_de && cam_href && !cam_vsync;
    // Once the eol byte has been taken the line is full; anything further is an overlong line.
    assign drop_long   = accept && line_full_q;
    assign drop_full   = accept && !line_full_q && fifo_full;
    assign do_write    = accept && !line_full_q && !fifo_full;
    assign line_end    = in_active && href_fall;
    assign last_line   = (line_cnt_q == LW'(LINES_PER_FRAME - 1));
    assign abort       = in_active && vsync_rise;
    assign tag_sof     = (line_cnt_q == '0) && (byte_cnt_q == '0);
    assign tag_eol     = (byte_cnt_q == BW'(BYTES_PER_LINE - 1));
    assign drained     = fifo_empty && (buf_cnt_q == 2'd0) && !rd_inflight_q && !wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (arm) state_d = StWaitFrame;
            StWaitFrame: if (vsync_fall) state_d = StActive;
            StActive: begin
                if (abort) state_d = StWaitFrame;
                else if (line_end && last_line) state_d = StFlush;
            end
            StFlush:     if (drained) state_d = cont ? StWaitFrame : StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = (state_q == StFlush) && drained;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            byte_cnt_q  <= '0;
            line_cnt_q  <= '0;
            line_full_q <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            ovf_q       <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            vsync_q <= cam_vsync;
            href_q  <= cam_href;
            wr_q    <= do_write;
            if (do_write) wdata_q <= {tag_sof, tag_eol, cam_data};
            if (frame_start) begin
                byte_cnt_q  <= '0;
                line_cnt_q  <= '0;
                line_full_q <= 1'b0;
            end else if (line_end) begin
                byte_cnt_q  <= '0;
                line_full_q <= 1'b0;
                if (!last_line) line_cnt_q <= line_cnt_q + LW'(1);
            end else if (accept && !line_full_q) begin
                if (tag_eol) line_full_q <= 1'b1;
                else         byte_cnt_q  <= byte_cnt_q + BW'(1);
            end
            // A new error outranks a clear in the same cycle.
            if (drop_full)      ovf_q <= 1'b1;
            else if (clear_err) ovf_q <= 1'b0;
            if (drop_long || (line_end && !line_full_q) || abort) len_err_q <= 1'b1;
            else if (clear_err)                                  len_err_q <= 1'b0;
        end
    end

    assign fifo_wr    = wr_q;
    assign fifo_wdata = wdata_q;
    assign ovf        = ovf_q;
    assign len_err    = len_err_q;

    // Read credit counts the read in flight so the buffer can never overfill.
    assign rd_credit = buf_cnt_q + {1'b0, rd_inflight_q};
    assign fifo_rd   = !rst && !fifo_empty && (rd_credit < 2'd2);
    assign out_valid = (buf_cnt_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign {out_sof, out_eol, out_data} = buf_mem_q[buf_rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_inflight_q <= 1'b0;
            buf_cnt_q     <= 2'd0;
            buf_wptr_q    <= 1'b0;
            buf_rptr_q    <= 1'b0;
            buf_mem_q[0]  <= '0;
            buf_mem_q[1]  <= '0;
        end else begin
            rd_inflight_q <= fifo_rd;
            if (rd_inflight_q) begin
                buf_mem_q[buf_wptr_q] <= fifo_rdata;
                buf_wptr_q            <= ~buf_wptr_q;
            end
            if (pop) buf_rptr_q <= ~buf_rptr_q;
            buf_cnt_q <= buf_cnt_q + {1'b0, rd_inflight_q} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_cam_fifo_sequencer.sv
// Scoreboard bench for cam_fifo_sequencer with a behavioural 1-cycle-latency FIFO
// (4 bytes/line, 2 lines/frame).
module tb_cam_fifo_sequencer;
    localparam int BPL = 4;
    localparam int LPF = 2;
    localparam int FDEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, arm = 1'b0, cont = 1'b0, clear_err = 1'b0;
    logic       cam_vsync = 1'b0, cam_href = 1'b0, cam_de = 1'b0;
    logic [7:0] cam_data = 8'h00;
    logic       fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [9:0] fifo_wdata, fifo_rdata;
    logic       out_valid, out_ready = 1'b1, out_sof, out_eol;
    logic [7:0] out_data;
    logic       busy, frame_done, ovf, len_err;

    int         checks = 0, failures = 0;
    logic [9:0] fq[$];
    int         fcnt = 0;
    logic       force_full = 1'b0;
    logic [9:0] sb[$];
    int         fd_count = 0;
    logic       stall_prev = 1'b0;
    logic [9:0] held = '0;

    cam_fifo_sequencer #(.DATA_W(8), .BYTES_PER_LINE(BPL), .LINES_PER_FRAME(LPF)) dut (
        .clk(clk), .rst(rst), .arm(arm), .cont(cont), .clear_err(clear_err),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_de(cam_de), .cam_data(cam_data),
        .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .busy(busy), .frame_done(frame_done),
        .ovf(ovf), .len_err(len_err)
    );

    assign fifo_empty = (fcnt == 0);
    assign fifo_full  = force_full || (fcnt >= FDEPTH);

    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fifo_rdata <= '0;
        end else begin
            if (fifo_rd && fq.size() > 0) fifo_rdata <= fq.pop_front();
            if (fifo_wr) fq.push_back(fifo_wdata);
        end
        fcnt <= fq.size();
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] exp;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (frame_done) fd_count++;
            if (stall_prev) check("hold", {out_valid, out_sof, out_eol, out_data}, {1'b1, held});
            if (out_valid && out_ready) begin
                exp = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 11'h7ff;
                check("out", {1'b0, out_sof, out_eol, out_data}, exp);
            end
            stall_prev = out_valid && !out_ready;
            held = {out_sof, out_eol, out_data};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic start_frame;
        cam_vsync = 1'b1;
        tick();
        tick();
        cam_vsync = 1'b0;
        tick();
    endtask

    task automatic put_byte(input logic [7:0] d, input logic keep, input logic sof,
                            input logic eol, input logic full);
        cam_href = 1'b1;
        cam_de = 1'b1;
        cam_data = d;
        force_full = full;
        if (keep) sb.push_back({sof, eol, d});
        tick();
        cam_de = 1'b0;
        force_full = 1'b0;
    endtask

    task automatic end_line;
        cam_href = 1'b0;
        cam_de = 1'b0;
        tick();
        tick();
    endtask

    task automatic full_line(input logic [7:0] base, input logic first);
        for (int i = 0; i < BPL; i++)
            put_byte(base + 8'(i), 1'b1, first && (i == 0), i == BPL - 1, 1'b0);
        end_line();
    endtask

    task automatic nominal_frame(input logic [7:0] b0, input logic [7:0] b1);
        do_arm();
        start_frame();
        full_line(b0, 1'b1);
        full_line(b1, 1'b0);
    endtask

    task automatic wait_done(input string tag, input int fd0);
        int n = 0;
        while (!(sb.size() == 0 && fd_count > fd0) && n < 300) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({tag, "_frame_done"}, fd_count - fd0, 1);
        check({tag, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        int fd0;
        // Reset
        tick();
        tick();
        rst = 1'b0;
        check("reset_zero", {fifo_wr, fifo_wdata, fifo_rd, out_valid, out_data, out_sof, out_eol,
                             busy, frame_done, ovf, len_err}, 0);

        // Nominal frame
        fd0 = fd_count;
        nominal_frame(8'h10, 8'h20);
        wait_done("nominal", fd0);
        check("nominal_busy", busy, 0);
        check("nominal_err", {ovf, len_err}, 0);

        // Backpressure
        fd0 = fd_count;
        fork
            nominal_frame(8'h10, 8'h20);
            begin
                for (int i = 0; i < 40; i++) begin
                    out_ready = (i % 2 == 0) && !(i >= 20 && i < 23);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        wait_done("bp", fd0);

        // Overflow on 0x12
        fd0 = fd_count;
        do_arm();
        start_frame();
        put_byte(8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        put_byte(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        put_byte(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        put_byte(8'h13, 1'b1, 1'b0, 1'b1, 1'b0);
        end_line();
        full_line(8'h20, 1'b0);
        wait_done("ovf", fd0);
        check("ovf_set", {ovf, len_err}, 2'b10);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("ovf_clear", ovf, 0);

        // Short line then full line
        fd0 = fd_count;
        do_arm();
        start_frame();
        put_byte(8'h20, 1'b1, 1'b1, 1'b0, 1'b0);
        put_byte(8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
        put_byte(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        end_line();
        check("short_len_err", len_err, 1);
        full_line(8'h30, 1'b0);
        wait_done("short", fd0);
        check("short_ovf", ovf, 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("len_clear", len_err, 0);

        // Long line: fifth byte dropped
        fd0 = fd_count;
        do_arm();
        start_frame();
        for (int i = 0; i < BPL; i++) put_byte(8'h10 + 8'(i), 1'b1, i == 0, i == BPL - 1, 1'b0);
        put_byte(8'h14, 1'b0, 1'b0, 1'b0, 1'b0);
        end_line();
        check("long_len_err", len_err, 1);
        full_line(8'h20, 1'b0);
        wait_done("long", fd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;

        // Reset mid-frame after 5 bytes (fifth dropped as overflow so ovf is live at reset)
        do_arm();
        start_frame();
        full_line(8'h10, 1'b1);
        put_byte(8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
        check("pre_reset_ovf", ovf, 1);
        rst = 1'b1;
        sb.delete();
        cam_href = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("midreset_zero", {fifo_wr, fifo_wdata, fifo_rd, out_valid, out_data, out_sof,
                                out_eol, busy, frame_done, ovf, len_err}, 0);
        fd0 = fd_count;
        nominal_frame(8'h40, 8'h50);
        wait_done("post_reset", fd0);
        check("post_reset_err", {ovf, len_err, busy}, 0);

        // Continuous mode stays busy waiting for the next frame
        cont = 1'b1;
        fd0 = fd_count;
        nominal_frame(8'h60, 8'h70);
        wait_done("cont", fd0);
        check("cont_busy", busy, 1);
        cont = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
